// File: rtl/clk_div_ctrl.sv
// Run-time controller for the system clock divider: glitch-free divided clock,
// per-toggle tick enable and a valid/ready divisor update applied on half-period boundaries.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 14,
  parameter int unsigned DEFAULT_DIV = 14000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] div_cur
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_d;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] div_eff;
  logic             clk_d;
  logic             tick_d;
  logic             ready_d;
  logic             running_d;
  logic             tc;
  logic             xfer;

  // A zero divisor behaves as one so the counter always has a terminal value.
  assign div_eff = (div_cur == '0) ? CNT_W'(1) : div_cur;
  assign tc      = (state_q != ST_STOPPED) && (cnt_q == (div_eff - CNT_W'(1)));
  assign xfer    = cfg_valid && cfg_ready;

  // State register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter, divisor and handshake logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_out;
    tick_d  = 1'b0;
    div_d   = div_cur;
    pend_d  = pend_q;
    ready_d = cfg_ready;

    case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (xfer) begin
          div_d = cfg_div;
        end
        if (en) begin
          state_d = ST_RUNNING;
        end
      end

      ST_RUNNING, ST_STOPPING: begin
        if (tc) begin
          cnt_d  = '0;
          clk_d  = ~clk_out;
          tick_d = 1'b1;
          // A value accepted earlier takes effect only once the current half-period ends.
          if (!cfg_ready) begin
            div_d   = pend_q;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (xfer) begin
          pend_d  = cfg_div;
          ready_d = 1'b0;
        end

        if (state_q == ST_RUNNING) begin
          if (!en) begin
            state_d = ST_STOPPING;
          end
        end else if (en) begin
          state_d = ST_RUNNING;
        end else if (tc && clk_out) begin
          // Park only after a falling toggle; nothing may remain pending once stopped.
          state_d = ST_STOPPED;
          if (xfer) begin
            div_d   = cfg_div;
            ready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_STOPPED;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    running_d = (state_d != ST_STOPPED);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      div_cur   <= CNT_W'(DEFAULT_DIV);
      pend_q    <= '0;
      cfg_ready <= 1'b1;
      running   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out   <= clk_d;
      tick      <= tick_d;
      div_cur   <= div_d;
      pend_q    <= pend_d;
      cfg_ready <= ready_d;
      running   <= running_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: table of start/stop runs plus hand sequences for reload,
// stop cancel, reload at a terminal count and asynchronous reset; ticks checked via a scoreboard.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF   = 4;

  typedef struct {
    int   cyc;
    logic lvl;
  } exp_t;

  typedef struct {
    logic [CNT_W-1:0] div;
    int               hold;
    int               half;
    int               toggles;
  } vec_t;

  logic             clk_in = 1'b0;
  logic             reset_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] div_cur;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[7];

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .div_cur   (div_cur)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Expected toggles j = 1..n at cycle s + p*j; odd toggles rise, even toggles fall.
  task automatic push_run(input int s, input int p, input int n);
    for (int j = 1; j <= n; j++) begin
      sb.push_back('{s + p * j, (j % 2) == 1});
    end
  endtask

  task automatic push_one(input int c, input logic lvl);
    sb.push_back('{c, lvl});
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 400;
    while (sb.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected ticks never arrived, required 0 outstanding", name, sb.size());
      sb.delete();
    end
  endtask

  // Loads a divisor while stopped and starts in the same cycle; returns the start edge.
  task automatic start(input logic [CNT_W-1:0] d, output int s);
    s         = cyc + 1;
    en        = 1'b1;
    cfg_valid = 1'b1;
    cfg_div   = d;
    go(s);
    cfg_valid = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (reset_n && tick) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got tick at cycle %0d clk_out=%0b, expected none", cyc, clk_out);
        end else begin
          e = sb.pop_front();
          chk("tick_cycle", cyc, e.cyc);
          chk("tick_level", int'(clk_out), int'(e.lvl));
        end
      end
    end
  endtask

  initial begin
    int s;

    vecs[0] = '{8'd4, 2, 4, 2};
    vecs[1] = '{8'd4, 6, 4, 2};
    vecs[2] = '{8'd3, 3, 3, 2};
    vecs[3] = '{8'd6, 13, 6, 4};
    vecs[4] = '{8'd1, 5, 1, 6};
    vecs[5] = '{8'd0, 4, 1, 6};
    vecs[6] = '{8'd2, 9, 2, 6};

    reset_n   = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    step(3);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_running", int'(running), 0);
    chk("rst_div_cur", int'(div_cur), DEF);
    #3 reset_n = 1'b1;
    step(1);

    fork
      monitor();
    join_none

    // Table: load and start together, hold en for 'hold' edges, then let it park.
    foreach (vecs[i]) begin
      chk("pre_ready", int'(cfg_ready), 1);
      push_run(cyc + 1, vecs[i].half, vecs[i].toggles);
      start(vecs[i].div, s);
      go(s + vecs[i].hold - 1);
      chk("run_running", int'(running), 1);
      en = 1'b0;
      drain("vec_drain");
      step(3 * vecs[i].half + 3);
      chk("stop_running", int'(running), 0);
      chk("stop_clk_out", int'(clk_out), 0);
      chk("stop_div_cur", int'(div_cur), int'(vecs[i].div));
      chk("stop_ready", int'(cfg_ready), 1);
    end

    // Live reload 4 -> 6 mid half-period; an offer while not ready is ignored.
    start(8'd4, s);
    push_one(s + 4, 1'b1);
    push_one(s + 8, 1'b0);
    push_one(s + 14, 1'b1);
    push_one(s + 20, 1'b0);
    go(s + 5);
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    go(s + 6);
    chk("reload_ready_low", int'(cfg_ready), 0);
    chk("reload_div_old", int'(div_cur), 4);
    cfg_div = 8'd2;
    go(s + 7);
    cfg_valid = 1'b0;
    go(s + 8);
    chk("reload_div_new", int'(div_cur), 6);
    chk("reload_ready_back", int'(cfg_ready), 1);
    go(s + 14);
    en = 1'b0;
    drain("reload_drain");
    step(10);
    chk("reload_running", int'(running), 0);
    chk("reload_div_final", int'(div_cur), 6);

    // Stop cancel: en dips for two edges inside one half-period.
    start(8'd4, s);
    push_run(s, 4, 6);
    go(s + 4);
    en = 1'b0;
    go(s + 6);
    chk("cancel_running", int'(running), 1);
    en = 1'b1;
    go(s + 16);
    en = 1'b0;
    drain("cancel_drain");
    step(10);
    chk("cancel_stopped", int'(running), 0);

    // Offer landing on a terminal-count edge applies one terminal count later.
    start(8'd4, s);
    push_one(s + 4, 1'b1);
    push_one(s + 8, 1'b0);
    push_one(s + 10, 1'b1);
    push_one(s + 12, 1'b0);
    go(s + 3);
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    go(s + 4);
    cfg_valid = 1'b0;
    chk("tcoffer_ready_low", int'(cfg_ready), 0);
    chk("tcoffer_div_old", int'(div_cur), 4);
    go(s + 8);
    chk("tcoffer_div_new", int'(div_cur), 2);
    chk("tcoffer_ready_back", int'(cfg_ready), 1);
    en = 1'b0;
    drain("tcoffer_drain");
    step(6);
    chk("tcoffer_stopped", int'(running), 0);

    // Asynchronous reset while high with a pending value.
    start(8'd4, s);
    push_one(s + 4, 1'b1);
    go(s + 5);
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    go(s + 6);
    cfg_valid = 1'b0;
    chk("arst_pending", int'(cfg_ready), 0);
    chk("arst_high_before", int'(clk_out), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_div_cur", int'(div_cur), DEF);
    chk("arst_ready", int'(cfg_ready), 1);
    chk("arst_running", int'(running), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_sb_empty", sb.size(), 0);
    en = 1'b0;
    step(2);
    #3 reset_n = 1'b1;
    step(1);

    // Restart without a load: the discarded pending value must not appear.
    s  = cyc + 1;
    en = 1'b1;
    push_run(s, 4, 2);
    go(s + 4);
    en = 1'b0;
    drain("arst_restart_drain");
    step(8);
    chk("arst_restart_div", int'(div_cur), DEF);
    chk("arst_restart_stopped", int'(running), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
